// File: rtl/hex_line_formatter_if.sv
// rtl/hex_line_formatter_if.sv - byte-stream and line/send/ready bundle for hex_line_formatter
// master: byte feeder and UART writer side; slave: the formatter.
interface hex_line_formatter_if #(
  parameter int LINE_CHARS = 80
);
  logic                    start;
  logic [15:0]             base_addr;
  logic [7:0]              byte_data;
  logic                    byte_valid;
  logic                    byte_last;
  logic                    byte_ready;
  logic [8*LINE_CHARS-1:0] line;
  logic                    send;
  logic                    writer_ready;
  logic                    busy;

  modport master (
    output start, base_addr, byte_data, byte_valid, byte_last, writer_ready,
    input  byte_ready, line, send, busy
  );

  modport slave (
    input  start, base_addr, byte_data, byte_valid, byte_last, writer_ready,
    output byte_ready, line, send, busy
  );
endinterface

// File: rtl/hex_line_formatter.sv
// rtl/hex_line_formatter.sv - packs a byte stream into 80-char ASCII hex-dump lines for the UART writer
// Optional ASCII column enabled by defining HEX_LINE_ASCII_COL_EN.
module hex_line_formatter #(
  parameter int BYTES_PER_LINE = 16,
  parameter int LINE_CHARS     = 80
) (
  input logic               clk,
  input logic               rst_n,
  hex_line_formatter_if.slave bus
);
  localparam int LINE_W = 8 * LINE_CHARS;
  localparam int N      = BYTES_PER_LINE;
  localparam int CW     = $clog2(N + 1);
`ifdef HEX_LINE_ASCII_COL_EN
  localparam int TERM   = 9 + 4 * N;
`else
  localparam int TERM   = 6 + 3 * N;
`endif

  typedef enum logic [1:0] {FILL, EMIT, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [15:0]       offset_q, offset_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              send_q, send_d;
  logic              accept;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  // Empty line: offset, ": ", all slots blank, terminator fixed at TERM.
  function automatic logic [LINE_W-1:0] blank_line(input logic [15:0] off);
    logic [LINE_W-1:0] l;
    l = '0;
    l[LINE_W-1  -: 8] = hex_char(off[15:12]);
    l[LINE_W-9  -: 8] = hex_char(off[11:8]);
    l[LINE_W-17 -: 8] = hex_char(off[7:4]);
    l[LINE_W-25 -: 8] = hex_char(off[3:0]);
    l[LINE_W-33 -: 8] = 8'h3A;
    l[LINE_W-41 -: 8] = 8'h20;
    for (int c = 6; c < 6 + 3 * N; c++) l[LINE_W-1-8*c -: 8] = 8'h20;
`ifdef HEX_LINE_ASCII_COL_EN
    l[LINE_W-1-8*(6+3*N) -: 8] = 8'h20;
    l[LINE_W-1-8*(7+3*N) -: 8] = 8'h7C;
    for (int c = 8 + 3 * N; c < 8 + 4 * N; c++) l[LINE_W-1-8*c -: 8] = 8'h20;
    l[LINE_W-1-8*(8+4*N) -: 8] = 8'h7C;
`endif
    l[LINE_W-1-8*TERM     -: 8] = 8'h0D;
    l[LINE_W-1-8*(TERM+1) -: 8] = 8'h0A;
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] put_byte(input logic [LINE_W-1:0] l,
                                                 input logic [CW-1:0] k,
                                                 input logic [7:0] b);
    logic [LINE_W-1:0] r;
    int                p;
    r = l;
    p = 6 + 3 * int'(k);
    r[LINE_W-1-8*p     -: 8] = hex_char(b[7:4]);
    r[LINE_W-1-8*(p+1) -: 8] = hex_char(b[3:0]);
`ifdef HEX_LINE_ASCII_COL_EN
    r[LINE_W-1-8*(8+3*N+int'(k)) -: 8] = (b >= 8'h20 && b <= 8'h7E) ? b : 8'h2E;
`endif
    return r;
  endfunction

  assign accept = (state_q == FILL) && bus.byte_valid;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    offset_d = offset_q;
    line_d   = line_q;
    send_d   = 1'b0;
    case (state_q)
      FILL: begin
        if (bus.start && count_q == '0) offset_d = bus.base_addr;
        // First byte rebuilds the whole template so a start in the same cycle shows up in the header.
        if (accept) begin
          line_d  = put_byte((count_q == '0) ? blank_line(offset_d) : line_q, count_q, bus.byte_data);
          count_d = count_q + CW'(1);
          if (int'(count_q) + 1 == N || bus.byte_last) state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.writer_ready) begin
          send_d  = 1'b1;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!bus.writer_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.writer_ready) begin
          offset_d = offset_q + 16'(count_q);
          count_d  = '0;
          line_d   = blank_line(offset_d);
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      count_q  <= '0;
      offset_q <= 16'h0000;
      line_q   <= '0;
      send_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      offset_q <= offset_d;
      line_q   <= line_d;
      send_q   <= send_d;
    end
  end

  assign bus.line       = line_q;
  assign bus.send       = send_q;
  assign bus.byte_ready = rst_n && (state_q == FILL);
  assign bus.busy       = (count_q != '0) || (state_q != FILL);
endmodule
